// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side stream master.
package fifo_rd_pkg;

  localparam int SKID_DEPTH_DEF = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_e;

  // A threshold of zero would start a burst on an empty FIFO; clamp it to one.
  function automatic logic [15:0] eff_thresh(input logic [15:0] thresh);
    return (thresh == 16'd0) ? 16'd1 : thresh;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream with burst framing, as produced by the FIFO read master.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// Small circular buffer that absorbs words already popped from the FIFO.
module fifo_rd_skid #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for sync_fifo: threshold-started bursts popped into a skid buffer.
//   state | meaning
//   IDLE  | waiting for level >= threshold (or flush) with FIFO not empty
//   DRAIN | popping while buffer has room, until a last-tagged pop or FIFO empty
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [FIFO_PTR:0]     cfg_thresh,
  input  logic [FIFO_PTR:0]     cfg_burst_len,
  output logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  fifo_rd_stream_if.master      out_if,
  output logic                  busy
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [FIFO_PTR:0] ONE = {{FIFO_PTR{1'b0}}, 1'b1};

  rd_state_e           state_q, state_d;
  logic [FIFO_PTR:0]   beat_cnt_q, beat_cnt_d;
  logic [FIFO_PTR:0]   burst_len_q, burst_len_d;
  logic                inflight_q, inflight_d;
  logic                last_tag_q, last_tag_d;
  logic                start, room, pop_tag;
  logic [CW-1:0]       buf_cnt;
  logic [FIFO_WIDTH:0] head;
  logic                out_valid;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    start   = en & ~fifo_empty &
              ((16'(fifo_data_avail) >= eff_thresh(16'(cfg_thresh))) | flush);
    room    = (32'(buf_cnt) + 32'(inflight_q)) < 32'(SKID_DEPTH);
    // Level of exactly one means this pop empties the FIFO; later writes start a new burst.
    pop_tag = ((burst_len_q != '0) & (beat_cnt_q == burst_len_q - ONE)) |
              (fifo_data_avail == ONE);
    fifo_rden  = (state_q == DRAIN) & en & ~fifo_empty & room;
    inflight_d = fifo_rden;
    last_tag_d = fifo_rden & pop_tag;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRAIN;
          beat_cnt_d  = '0;
          burst_len_d = cfg_burst_len;
        end
      end
      DRAIN: begin
        if (fifo_rden) begin
          beat_cnt_d = beat_cnt_q + ONE;
          if (pop_tag) state_d = IDLE;
        end else if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
      inflight_q  <= 1'b0;
      last_tag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      inflight_q  <= inflight_d;
      last_tag_q  <= last_tag_d;
    end
  end

  fifo_rd_skid #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (FIFO_WIDTH + 1)
  ) u_skid (
    .clk       (fifo_clk),
    .rst       (fifo_rst),
    .push      (inflight_q),
    .push_data ({last_tag_q, fifo_rddata}),
    .pop       (out_valid & out_if.ready),
    .head      (head),
    .count     (buf_cnt)
  );

  assign out_valid    = (buf_cnt != '0);
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? head[FIFO_WIDTH-1:0] : '0;
  assign out_if.last  = out_valid & head[FIFO_WIDTH];
  assign busy         = (state_q == DRAIN) | inflight_q | out_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based sync_fifo model, popped-word scoreboard, directed and random traffic.
module tb_fifo_rd_stream;

  localparam int W = 8;
  localparam int P = 4;

  logic         fifo_clk = 1'b0;
  logic         fifo_rst = 1'b1;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic [P:0]   cfg_thresh = 5'd1;
  logic [P:0]   cfg_burst_len = 5'd0;
  logic         fifo_rden;
  logic [W-1:0] fifo_rddata = '0;
  logic         fifo_empty = 1'b1;
  logic [P:0]   fifo_data_avail = '0;
  logic         busy;

  fifo_rd_stream_if #(.WIDTH(W)) s_if ();

  fifo_rd_stream #(.FIFO_PTR(P), .FIFO_WIDTH(W), .SKID_DEPTH(3)) dut (
    .fifo_clk        (fifo_clk),
    .fifo_rst        (fifo_rst),
    .en              (en),
    .flush           (flush),
    .cfg_thresh      (cfg_thresh),
    .cfg_burst_len   (cfg_burst_len),
    .fifo_rden       (fifo_rden),
    .fifo_rddata     (fifo_rddata),
    .fifo_empty      (fifo_empty),
    .fifo_data_avail (fifo_data_avail),
    .out_if          (s_if),
    .busy            (busy)
  );

  always #5 fifo_clk = ~fifo_clk;

  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] fq [$];
  logic [W-1:0] exp_mem [0:2047];
  logic [W-1:0] wr_mem  [0:255];
  logic [W-1:0] log_data [0:2047];
  logic         log_last [0:2047];
  int           log_cyc  [0:2047];
  int log_n = 0, pop_idx = 0, rd_idx = 0, flush_to = 0;
  int cyc = 0, rden_cnt = 0;
  int n_tests = 0, n_fail = 0;
  logic wr_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sync_fifo behaviour: registered read data, pop before push, occupancy after both.
  task automatic fifo_model();
    logic [W-1:0] w;
    forever begin
      @(posedge fifo_clk);
      cyc++;
      if (fifo_rden) begin
        rden_cnt++;
        if (fq.size() > 0) begin
          w = fq.pop_front();
          fifo_rddata <= w;
          exp_mem[pop_idx] = w;
          pop_idx++;
        end
      end
      if (fifo_rst) flush_to = pop_idx;
      if (wr_en && fq.size() < 16) fq.push_back(wr_data);
      fifo_empty      <= (fq.size() == 0);
      fifo_data_avail <= 5'(fq.size());
    end
  endtask

  task automatic monitor();
    logic [W-1:0] pd = '0;
    logic         pl = 1'b0;
    logic         stall = 1'b0;
    int           beats = 0;
    forever begin
      @(negedge fifo_clk);
      #2;
      if (rd_idx < flush_to) rd_idx = flush_to;
      if (fifo_rst) begin
        stall = 1'b0;
        beats = 0;
      end else begin
        if (fifo_rden) check("rden_while_empty", fifo_empty, 0);
        if (pop_idx > rd_idx) check("busy_with_pending_word", busy, 1);
        if (stall) check("stall_valid_held", s_if.valid, 1);
        if (s_if.valid) begin
          if (pop_idx <= rd_idx) check("valid_without_word", s_if.valid, 0);
          else check("out_data", s_if.data, exp_mem[rd_idx]);
          if (stall) begin
            check("stall_data_stable", s_if.data, pd);
            check("stall_last_stable", s_if.last, pl);
          end
          if (s_if.ready) begin
            log_data[log_n] = s_if.data;
            log_last[log_n] = s_if.last;
            log_cyc[log_n]  = cyc;
            log_n++;
            rd_idx++;
            beats++;
            if (cfg_burst_len != 0)
              check("burst_cap", (beats <= int'(cfg_burst_len)) ? 1 : 0, 1);
            if (s_if.last) beats = 0;
          end
        end
        stall = s_if.valid & ~s_if.ready;
        pd    = s_if.data;
        pl    = s_if.last;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge fifo_clk);
  endtask

  task automatic push_words(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + W'(i);
      @(negedge fifo_clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    step(2);
    while (!(!busy && fifo_empty) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) check({name, "_timeout_busy"}, busy, 0);
  endtask

  task automatic check_burst(input string name, input int lb, input int n,
                             input logic [W-1:0] base, input logic [31:0] last_mask);
    check({name, "_count"}, log_n - lb, n);
    for (int i = 0; i < n; i++) begin
      check({name, "_data"}, log_data[lb + i], base + W'(i));
      check({name, "_last"}, log_last[lb + i], last_mask[i]);
    end
  endtask

  initial begin
    int rb, lb, k;
    s_if.ready = 1'b0;
    fork
      fifo_model();
      monitor();
    join_none

    step(3);
    check("rst_valid", s_if.valid, 0);
    check("rst_last", s_if.last, 0);
    check("rst_data", s_if.data, 0);
    check("rst_rden", fifo_rden, 0);
    check("rst_busy", busy, 0);
    fifo_rst = 1'b0;
    step(1);

    // Threshold start
    cfg_thresh = 5'd4; cfg_burst_len = 5'd0; s_if.ready = 1'b1; en = 1'b1;
    rb = rden_cnt; lb = log_n;
    push_words(8'h10, 3);
    step(4);
    check("thr_no_rden", rden_cnt - rb, 0);
    check("thr_busy_idle", busy, 0);
    push_words(8'h13, 1);
    step(1);
    check("thr_rden_high", fifo_rden, 1);
    wait_done("thr", 40);
    check_burst("thr", lb, 4, 8'h10, 32'b1000);
    check("thr_rden_total", rden_cnt - rb, 4);
    check("thr_fifo_empty", fifo_empty, 1);

    // Burst cap 5 over 16 words
    en = 1'b0; cfg_thresh = 5'd1; cfg_burst_len = 5'd5;
    lb = log_n;
    push_words(8'h20, 16);
    en = 1'b1;
    wait_done("cap", 200);
    check_burst("cap", lb, 16, 8'h20, 32'b1100_0010_0001_0000);
    for (int i = 1; i < 16; i++)
      if (!log_last[lb + i - 1])
        check("cap_no_gap", log_cyc[lb + i] - log_cyc[lb + i - 1], 1);

    // Backpressure
    en = 1'b0; cfg_burst_len = 5'd0; s_if.ready = 1'b0;
    lb = log_n;
    push_words(8'h30, 10);
    rb = rden_cnt;
    en = 1'b1;
    step(10);
    check("bp_rden_pulses", rden_cnt - rb, 3);
    check("bp_rden_low", fifo_rden, 0);
    check("bp_valid", s_if.valid, 1);
    check("bp_head", s_if.data, 8'h30);
    s_if.ready = 1'b1;
    wait_done("bp", 100);
    check_burst("bp", lb, 10, 8'h30, 32'b10_0000_0000);

    // Flush below threshold
    cfg_thresh = 5'd8;
    rb = rden_cnt; lb = log_n;
    push_words(8'h40, 2);
    step(4);
    check("fl_no_rden", rden_cnt - rb, 0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_done("fl", 40);
    check_burst("fl", lb, 2, 8'h40, 32'b10);
    check("fl_fifo_empty", fifo_empty, 1);
    check("fl_busy", busy, 0);

    // Reset with words buffered
    en = 1'b0; cfg_thresh = 5'd1; s_if.ready = 1'b0;
    push_words(8'h50, 6);
    en = 1'b1;
    step(8);
    check("mr_valid_before", s_if.valid, 1);
    check("mr_head_before", s_if.data, 8'h50);
    fifo_rst = 1'b1;
    step(1);
    fifo_rst = 1'b0;
    check("mr_valid", s_if.valid, 0);
    check("mr_rden", fifo_rden, 0);
    check("mr_busy", busy, 0);
    lb = log_n;
    s_if.ready = 1'b1;
    wait_done("mr", 60);
    check_burst("mr", lb, 3, 8'h53, 32'b100);

    // Random traffic
    cfg_thresh = 5'($urandom_range(1, 6));
    cfg_burst_len = 5'($urandom_range(0, 7));
    lb = log_n;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          k = 0;
          while (fifo_data_avail == 5'd16 && k < 200) begin
            step(1);
            k++;
          end
          if (k >= 200) check("rnd_writer_timeout_avail", fifo_data_avail, 15);
          wr_mem[i] = W'($urandom);
          wr_en = 1'b1;
          wr_data = wr_mem[i];
          step(1);
          wr_en = 1'b0;
          step($urandom_range(0, 4));
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          s_if.ready = 1'b0;
          step($urandom_range(0, 4));
          s_if.ready = 1'b1;
          step($urandom_range(1, 3));
        end
      end
    join
    s_if.ready = 1'b1;
    flush = 1'b1;
    wait_done("rnd", 3000);
    flush = 1'b0;
    check("rnd_count", log_n - lb, 256);
    for (int i = 0; i < 256; i++)
      check("rnd_order", log_data[lb + i], wr_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
